// File: rtl/wb_intercon_pkg.sv
// Shared types and defaults for the N-slave Wishbone interconnect.
package wb_intercon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF  = 32'hDEAD_BEEF;
  localparam logic [19:0] SLV_CODES_DEF = {4'h8, 4'h4, 4'h2, 4'h1, 4'h0};

  // Width needed for a counter that must reach TIMEOUT.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_intercon_n_if.sv
// Bus bundle between the PCI-side master, the slaves and the interconnect.
interface wb_intercon_n_if
  import wb_intercon_pkg::*;
#(
  parameter int NSLV = 5,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  // Handshake: master holds STB until it has seen ACK, then drops STB for at
  // least one cycle; ACK/ERR/VALID/DATA_O stay stable while STB remains high.
  logic [AW-1:0]      M_WB_ADD_I;
  logic [DW-1:0]      M_WB_DATA_I;
  logic [DW-1:0]      M_WB_DATA_O;
  logic               M_WB_STB_I;
  logic               M_WB_WE_I;
  logic               M_WB_ACK_O;
  logic               M_WB_VALID_O;
  logic               M_WB_ERR_O;
  logic [NSLV*AW-1:0] S_WB_ADD_O;
  logic [NSLV*DW-1:0] S_WB_DATA_O;
  logic [NSLV*DW-1:0] S_WB_DATA_I;
  logic [NSLV-1:0]    S_WB_ACK_I;
  logic [NSLV-1:0]    S_WB_VALID_I;
  logic [NSLV-1:0]    S_WB_STB_O;
  logic [NSLV-1:0]    S_WB_WE_O;
  state_t             dbg_state;

  // The bus environment: the master plus all attached slave devices.
  modport master (
    output M_WB_ADD_I, M_WB_DATA_I, M_WB_STB_I, M_WB_WE_I,
           S_WB_DATA_I, S_WB_ACK_I, S_WB_VALID_I,
    input  M_WB_DATA_O, M_WB_ACK_O, M_WB_VALID_O, M_WB_ERR_O,
           S_WB_ADD_O, S_WB_DATA_O, S_WB_STB_O, S_WB_WE_O, dbg_state
  );

  // The interconnect itself, a slave of the master bus.
  modport slave (
    input  M_WB_ADD_I, M_WB_DATA_I, M_WB_STB_I, M_WB_WE_I,
           S_WB_DATA_I, S_WB_ACK_I, S_WB_VALID_I,
    output M_WB_DATA_O, M_WB_ACK_O, M_WB_VALID_O, M_WB_ERR_O,
           S_WB_ADD_O, S_WB_DATA_O, S_WB_STB_O, S_WB_WE_O, dbg_state
  );

endinterface

// File: rtl/wb_addr_decode.sv
// Combinational priority decoder: address field against a packed code table.
module wb_addr_decode #(
  parameter int                    NSLV      = 5,
  parameter int                    DEC_W     = 4,
  parameter int                    IW        = 3,
  parameter logic [NSLV*DEC_W-1:0] SLV_CODES = '0
) (
  input  logic [DEC_W-1:0] field,
  output logic             hit,
  output logic [NSLV-1:0]  sel_oh,
  output logic [IW-1:0]    idx
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit    = 1'b0;
    sel_oh = '0;
    idx    = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (SLV_CODES[k*DEC_W +: DEC_W] == field) begin
        hit       = 1'b1;
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
        idx       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/wb_intercon_n.sv
// Single-master, N-slave Wishbone interconnect with timeout and abort support.
module wb_intercon_n
  import wb_intercon_pkg::*;
#(
  parameter int                    NSLV      = 5,
  parameter int                    AW        = 32,
  parameter int                    DW        = 32,
  parameter int                    DEC_LSB   = 12,
  parameter int                    DEC_W     = 4,
  parameter logic [NSLV*DEC_W-1:0] SLV_CODES = SLV_CODES_DEF,
  parameter int                    TIMEOUT   = 255,
  parameter logic [DW-1:0]         ERR_DATA  = ERR_DATA_DEF
) (
  input  logic           PHY_CLK33_I,
  input  logic           PHY_RST_I,
  wb_intercon_n_if.slave bus
);

  localparam int             IW      = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int             CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [IW-1:0]              sel_q, sel_d;
  logic                       ack_q, ack_d, err_q, err_d, valid_q, valid_d;
  logic [DW-1:0]              rdata_q, rdata_d;
  logic [NSLV-1:0]            stb_q, stb_d, we_q, we_d;
  logic [NSLV-1:0][AW-1:0]    add_q, add_d;
  logic [NSLV-1:0][DW-1:0]    wdata_q, wdata_d;
  logic [NSLV-1:0][DW-1:0]    s_rdata;

  logic                       dec_hit;
  logic [NSLV-1:0]            dec_oh;
  logic [IW-1:0]              dec_idx;

  assign s_rdata = bus.S_WB_DATA_I;

  wb_addr_decode #(
    .NSLV      (NSLV),
    .DEC_W     (DEC_W),
    .IW        (IW),
    .SLV_CODES (SLV_CODES)
  ) u_dec (
    .field  (bus.M_WB_ADD_I[DEC_LSB +: DEC_W]),
    .hit    (dec_hit),
    .sel_oh (dec_oh),
    .idx    (dec_idx)
  );

  always_ff @(posedge PHY_CLK33_I) begin
    if (PHY_RST_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      stb_q   <= '0;
      we_q    <= '0;
      add_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      add_q   <= add_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ack_d   = ack_q;
    err_d   = err_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    stb_d   = stb_q;
    we_d    = we_q;
    add_d   = add_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.M_WB_STB_I) begin
          if (dec_hit) begin
            sel_d          = dec_idx;
            stb_d          = dec_oh;
            add_d[dec_idx]   = bus.M_WB_ADD_I;
            wdata_d[dec_idx] = bus.M_WB_DATA_I;
            we_d[dec_idx]    = bus.M_WB_WE_I;
            state_d        = WAIT;
          end else begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            valid_d = 1'b0;
            rdata_d = ERR_DATA;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.M_WB_STB_I) begin
          stb_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bus.S_WB_ACK_I[sel_q]) begin
          // Slave ACK beats a coincident timeout.
          stb_d   = '0;
          rdata_d = s_rdata[sel_q];
          valid_d = bus.S_WB_VALID_I[sel_q];
          ack_d   = 1'b1;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          stb_d   = '0;
          rdata_d = ERR_DATA;
          valid_d = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (!bus.M_WB_STB_I) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.M_WB_ACK_O   = ack_q;
  assign bus.M_WB_ERR_O   = err_q;
  assign bus.M_WB_VALID_O = valid_q;
  assign bus.M_WB_DATA_O  = rdata_q;
  assign bus.S_WB_STB_O   = stb_q;
  assign bus.S_WB_WE_O    = we_q;
  assign bus.S_WB_ADD_O   = add_q;
  assign bus.S_WB_DATA_O  = wdata_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_wb_intercon_n.sv
// Self-checking bench for wb_intercon_n against a transaction-level model.
module tb_wb_intercon_n;
  import wb_intercon_pkg::*;

  localparam int          NS  = 5;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: slave-side output registers and master read data.
  logic [31:0] m_add  [NS];
  logic [31:0] m_data [NS];
  logic        m_we   [NS];
  logic [31:0] m_rdata;
  int          codes  [NS] = '{0, 1, 2, 4, 8};

  wb_intercon_n_if #(.NSLV(NS), .AW(32), .DW(32)) bus ();

  wb_intercon_n #(.NSLV(NS), .TIMEOUT(TO)) dut (
    .PHY_CLK33_I (clk),
    .PHY_RST_I   (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic int ref_slave(input logic [31:0] a);
    for (int k = 0; k < NS; k++)
      if (int'(a[15:12]) == codes[k]) return k;
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NS; k++) begin
      m_add[k] = '0; m_data[k] = '0; m_we[k] = 1'b0;
    end
    m_rdata = '0;
  endtask

  task automatic idle_inputs();
    bus.M_WB_ADD_I   = '0;
    bus.M_WB_DATA_I  = '0;
    bus.M_WB_STB_I   = 1'b0;
    bus.M_WB_WE_I    = 1'b0;
    bus.S_WB_DATA_I  = '0;
    bus.S_WB_ACK_I   = '0;
    bus.S_WB_VALID_I = '0;
  endtask

  // d: slave ACK is sampled d cycles after the request edge (0 = never).
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input int d, input logic [31:0] rd,
                         input logic rv, input int stray, input bit scramble);
    int          k;
    int          len;
    logic        e_err, e_v;
    logic [31:0] e_d;
    logic [NS-1:0] e_stb;
    k = ref_slave(addr);
    if (k < 0) begin
      len = 0; e_err = 1'b1; e_d = ERR; e_v = 1'b0;
    end else if (d >= 1 && d <= TO) begin
      len = d; e_err = 1'b0; e_d = rd; e_v = rv;
    end else begin
      len = TO; e_err = 1'b1; e_d = ERR; e_v = 1'b0;
    end
    if (k >= 0) begin
      m_add[k] = addr; m_data[k] = wdata; m_we[k] = we;
    end
    m_rdata = e_d;
    bus.M_WB_ADD_I = addr; bus.M_WB_DATA_I = wdata; bus.M_WB_WE_I = we;
    bus.M_WB_STB_I = 1'b1; bus.S_WB_ACK_I = '0;
    for (int i = 0; i <= len; i++) begin
      @(posedge clk); #1;
      e_stb = (k >= 0 && i < len) ? NS'(1 << k) : '0;
      n_checks++;
      if (bus.S_WB_STB_O !== e_stb) begin
        n_fail++; $display("FAIL slave_stb a=%h i=%0d got %b exp %b", addr, i, bus.S_WB_STB_O, e_stb);
      end
      n_checks++;
      if (bus.M_WB_ACK_O !== (i == len)) begin
        n_fail++; $display("FAIL m_ack a=%h i=%0d got %b exp %b", addr, i, bus.M_WB_ACK_O, (i == len));
      end
      if (i == 0 || i == len) begin
        for (int s = 0; s < NS; s++) begin
          n_checks++;
          if (bus.S_WB_ADD_O[s*32 +: 32] !== m_add[s] || bus.S_WB_DATA_O[s*32 +: 32] !== m_data[s] ||
              bus.S_WB_WE_O[s] !== m_we[s]) begin
            n_fail++; $display("FAIL slave_out s=%0d got %h/%h/%b exp %h/%h/%b", s,
              bus.S_WB_ADD_O[s*32 +: 32], bus.S_WB_DATA_O[s*32 +: 32], bus.S_WB_WE_O[s],
              m_add[s], m_data[s], m_we[s]);
          end
        end
      end
      if (i == len) begin
        n_checks++;
        if (bus.M_WB_ERR_O !== e_err || bus.M_WB_DATA_O !== e_d || bus.M_WB_VALID_O !== e_v) begin
          n_fail++; $display("FAIL resp a=%h got err=%b d=%h v=%b exp err=%b d=%h v=%b", addr,
            bus.M_WB_ERR_O, bus.M_WB_DATA_O, bus.M_WB_VALID_O, e_err, e_d, e_v);
        end
      end
      bus.S_WB_ACK_I = '0; bus.S_WB_VALID_I = '0;
      if (k >= 0 && i + 1 == d) begin
        bus.S_WB_ACK_I[k] = 1'b1; bus.S_WB_VALID_I[k] = rv; bus.S_WB_DATA_I[k*32 +: 32] = rd;
      end
      if (stray >= 0 && stray != k) begin
        bus.S_WB_ACK_I[stray] = 1'b1; bus.S_WB_VALID_I[stray] = 1'b1;
        bus.S_WB_DATA_I[stray*32 +: 32] = $urandom;
      end
      if (scramble) begin
        bus.M_WB_ADD_I = $urandom; bus.M_WB_DATA_I = $urandom; bus.M_WB_WE_I = 1'($urandom);
      end
    end
    // Late ACKs from every slave during RESP must not disturb the response.
    bus.S_WB_ACK_I = '1; bus.S_WB_VALID_I = '1; bus.S_WB_DATA_I = {NS{32'h5A5A_A5A5}};
    @(posedge clk); #1;
    n_checks++;
    if (bus.M_WB_ACK_O !== 1'b1 || bus.M_WB_ERR_O !== e_err || bus.M_WB_DATA_O !== e_d ||
        bus.M_WB_VALID_O !== e_v || bus.S_WB_STB_O !== '0) begin
      n_fail++; $display("FAIL hold a=%h got ack=%b err=%b d=%h v=%b stb=%b exp ack=1 err=%b d=%h v=%b stb=0",
        addr, bus.M_WB_ACK_O, bus.M_WB_ERR_O, bus.M_WB_DATA_O, bus.M_WB_VALID_O, bus.S_WB_STB_O, e_err, e_d, e_v);
    end
    idle_inputs();
    @(posedge clk); #1;
    n_checks++;
    if (bus.M_WB_ACK_O !== 1'b0 || bus.M_WB_ERR_O !== 1'b0 || bus.M_WB_VALID_O !== 1'b0 ||
        bus.M_WB_DATA_O !== m_rdata || bus.S_WB_STB_O !== '0) begin
      n_fail++; $display("FAIL release a=%h got ack=%b err=%b v=%b d=%h stb=%b exp 0/0/0 d=%h stb=0",
        addr, bus.M_WB_ACK_O, bus.M_WB_ERR_O, bus.M_WB_VALID_O, bus.M_WB_DATA_O, bus.S_WB_STB_O, m_rdata);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    n_checks++;
    if (bus.M_WB_ACK_O !== 1'b0 || bus.M_WB_ERR_O !== 1'b0 || bus.M_WB_VALID_O !== 1'b0 ||
        bus.M_WB_DATA_O !== '0 || bus.S_WB_STB_O !== '0 || bus.S_WB_WE_O !== '0 ||
        bus.S_WB_ADD_O !== '0 || bus.S_WB_DATA_O !== '0 || bus.dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_state got ack=%b err=%b stb=%b we=%b d=%h st=%0d exp all zero, IDLE",
        bus.M_WB_ACK_O, bus.M_WB_ERR_O, bus.S_WB_STB_O, bus.S_WB_WE_O, bus.M_WB_DATA_O, bus.dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_read();
    run_txn(32'h0000_2010, 32'h0, 1'b0, 1, 32'h1234_5678, 1'b1, -1, 1'b0);
  endtask

  task automatic test_write();
    run_txn(32'h0000_8000, 32'hCAFE_0001, 1'b1, 2, 32'h0BAD_0BAD, 1'b0, -1, 1'b0);
  endtask

  task automatic test_unmapped();
    run_txn(32'h0000_3000, 32'h1111_2222, 1'b1, 1, 32'h0, 1'b1, -1, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(32'h0000_0040, 32'h0, 1'b0, 0, 32'h0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_stray_tie();
    run_txn(32'h0000_4004, 32'h0, 1'b0, 3, 32'hAAAA_0003, 1'b1, 1, 1'b1);
    run_txn(32'h0000_4008, 32'h0, 1'b0, TO, 32'h7E57_0003, 1'b1, 1, 1'b0);
  endtask

  task automatic test_abort();
    bus.M_WB_ADD_I = 32'h0000_1234; bus.M_WB_DATA_I = 32'h0A0B_0C0D; bus.M_WB_WE_I = 1'b1;
    bus.M_WB_STB_I = 1'b1;
    m_add[1] = 32'h0000_1234; m_data[1] = 32'h0A0B_0C0D; m_we[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.S_WB_STB_O !== ((i < 3) ? 5'b00010 : 5'b00000) || bus.M_WB_ACK_O !== 1'b0) begin
        n_fail++; $display("FAIL abort i=%0d got stb=%b ack=%b exp stb=%b ack=0", i,
          bus.S_WB_STB_O, bus.M_WB_ACK_O, (i < 3) ? 5'b00010 : 5'b00000);
      end
      if (i == 2) bus.M_WB_STB_I = 1'b0;
    end
    n_checks++;
    if (bus.S_WB_ADD_O[63:32] !== m_add[1] || bus.S_WB_WE_O[1] !== m_we[1] || bus.M_WB_DATA_O !== m_rdata) begin
      n_fail++; $display("FAIL abort_regs got add=%h we=%b d=%h exp add=%h we=%b d=%h",
        bus.S_WB_ADD_O[63:32], bus.S_WB_WE_O[1], bus.M_WB_DATA_O, m_add[1], m_we[1], m_rdata);
    end
  endtask

  task automatic test_reset_mid();
    bus.M_WB_ADD_I = 32'h0000_0ABC; bus.M_WB_DATA_I = 32'h5555_6666; bus.M_WB_WE_I = 1'b1;
    bus.M_WB_STB_I = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.S_WB_STB_O !== 5'b00001) begin
      n_fail++; $display("FAIL rst_mid_stb got %b exp 00001", bus.S_WB_STB_O);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    model_clear();
    n_checks++;
    if (bus.S_WB_STB_O !== '0 || bus.M_WB_ACK_O !== 1'b0 || bus.M_WB_ERR_O !== 1'b0 ||
        bus.M_WB_VALID_O !== 1'b0 || bus.M_WB_DATA_O !== '0 || bus.S_WB_ADD_O !== '0 ||
        bus.S_WB_DATA_O !== '0 || bus.S_WB_WE_O !== '0 || bus.dbg_state !== IDLE) begin
      n_fail++; $display("FAIL rst_mid got stb=%b ack=%b err=%b we=%b st=%0d exp all zero, IDLE",
        bus.S_WB_STB_O, bus.M_WB_ACK_O, bus.M_WB_ERR_O, bus.S_WB_WE_O, bus.dbg_state);
    end
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    run_txn(32'h0000_0100, 32'h0, 1'b0, 3, 32'h0F0F_1234, 1'b1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int          stray;
      a = $urandom;
      stray = int'($urandom_range(0, NS)) - 1;
      run_txn(a, $urandom, 1'($urandom), int'($urandom_range(0, TO + 2)), $urandom,
              1'($urandom), stray, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_stray_tie();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_intercon_n.md
Name: wb_intercon_n

Overview:
- Parametrised single-master, N-slave Wishbone interconnect for the PCI-side internal bus.
- Decodes a configurable address field against a per-slave code table and forwards one registered request to exactly one slave.
- Returns the slave response to the master and holds it until the master drops strobe.
- New over the fixed 5-slave version: per-transaction state machine, request capture, ACK timeout, error response for unmapped/timed-out accesses, and master abort.

Parameters:
- NSLV, 5, number of slave ports (1..16).
- AW, 32, address width.
- DW, 32, data width.
- DEC_LSB, 12, LSB of the decode field in the address.
- DEC_W, 4, width of the decode field.
- SLV_CODES, {4'h8,4'h4,4'h2,4'h1,4'h0}, packed NSLV*DEC_W table; slice k is slave k's decode code (slave 0 in the LSBs).
- TIMEOUT, 255, cycles in WAIT before an error response (1..65535).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error.

Ports:
- PHY_CLK33_I  in  1  bus clock.
- PHY_RST_I  in  1  synchronous active-high reset.
- M_WB_ADD_I  in  AW  master address.
- M_WB_DATA_I  in  DW  master write data.
- M_WB_DATA_O  out  DW  read data to master.
- M_WB_STB_I  in  1  master strobe.
- M_WB_WE_I  in  1  master write enable.
- M_WB_ACK_O  out  1  acknowledge to master.
- M_WB_VALID_O  out  1  data-valid to master.
- M_WB_ERR_O  out  1  error qualifier (valid with ACK).
- S_WB_ADD_O  out  NSLV*AW  per-slave address.
- S_WB_DATA_O  out  NSLV*DW  per-slave write data.
- S_WB_DATA_I  in  NSLV*DW  per-slave read data.
- S_WB_ACK_I  in  NSLV  per-slave acknowledge.
- S_WB_VALID_I  in  NSLV  per-slave data-valid.
- S_WB_STB_O  out  NSLV  per-slave strobe.
- S_WB_WE_O  out  NSLV  per-slave write enable.

Behaviour:
- Clock and reset: one clock, PHY_CLK33_I. Reset PHY_RST_I is synchronous, active-high.
- Reset values: every output 0; state IDLE; timeout counter 0; captured registers 0.
- Reset asserted mid-transaction: state returns to IDLE at the next edge, all STB/ACK/ERR outputs drop, no response is issued.
- IDLE:
  - On an edge with M_WB_STB_I=1, capture ADD, DATA and WE; decode ADD[DEC_LSB +: DEC_W] against SLV_CODES.
  - Hit on slave k: load S_WB_ADD_O[k], S_WB_DATA_O[k] and S_WB_WE_O[k]; set S_WB_STB_O[k]=1; go to WAIT.
  - Multiple matching codes: lowest index wins.
  - No match: go to RESP with ACK=1, ERR=1, VALID=0, DATA_O=ERR_DATA. No slave strobe is raised.
- WAIT (sel=k): the counter increments each cycle. Checks are taken in this priority order:
  1. M_WB_STB_I=0 (abort): drop S_WB_STB_O[k], go to IDLE, no ACK.
  2. S_WB_ACK_I[k]=1: drop S_WB_STB_O[k]; latch DATA_O=S_WB_DATA_I[k] and VALID=S_WB_VALID_I[k]; set ACK=1, ERR=0; go to RESP.
  3. Counter==TIMEOUT-1: drop S_WB_STB_O[k]; set ACK=1, ERR=1, VALID=0, DATA_O=ERR_DATA; go to RESP.
  - ACK arriving in the same cycle as the timeout: ACK wins.
- RESP: ACK, ERR, VALID and DATA_O are held until an edge samples M_WB_STB_I=0. At that edge ACK, ERR and VALID clear, the counter clears and state goes to IDLE. DATA_O keeps its last value.
- Latency: master STB sampled at edge n gives slave STB after edge n. A slave ACK sampled at edge n+1 gives master ACK after edge n+1, so the minimum is 2 cycles. An unmapped access gives ACK after edge n.
- Invariants:
  - At most one S_WB_STB_O bit high at any time.
  - S_WB_ACK_I/VALID_I from non-selected slaves are ignored in all states.
  - Non-selected slave ADD/DATA/WE outputs hold their last values.
  - Master input changes during WAIT/RESP are ignored; the captured values are used.
- Back-to-back: a new transaction is accepted only from IDLE, i.e. at least one cycle with STB=0 between transactions.

Decomposition:
- Shared package wb_intercon_pkg:
  - state enum {IDLE, WAIT, RESP};
  - ERR_DATA default constant;
  - default SLV_CODES constant;
  - function for the counter width, clog2(TIMEOUT+1).
- One natural sub-module, wb_addr_decode: a combinational priority decoder giving hit, one-hot select and index from the address field, parametrised by NSLV, DEC_W and SLV_CODES.

Test Plan:
- Read slave 2: ADD=0x0000_2010, STB=1, slave 2 ACKs 1 cycle after its STB with DATA=0x1234_5678 and VALID=1. Required:
  - S_WB_STB_O=5'b00100 for exactly 1 cycle;
  - master ACK=1, ERR=0, DATA_O=0x1234_5678 two cycles after STB;
  - ACK clears the cycle after STB drops.
- Write slave 4: ADD=0x0000_8000, DATA=0xCAFE_0001, WE=1. Required: S_WB_ADD_O[4]=0x0000_8000, S_WB_DATA_O[4]=0xCAFE_0001, S_WB_WE_O[4]=1; all other slave outputs unchanged.
- Unmapped: ADD=0x0000_3000. Required: ACK=1, ERR=1, DATA_O=0xDEAD_BEEF one cycle after STB; no S_WB_STB_O bit ever set.
- Timeout: TIMEOUT=8, slave 0 never ACKs. Required: S_WB_STB_O[0] high 8 cycles, then ACK=1 and ERR=1. A late slave-0 ACK after that is ignored.
- Abort and reset: master drops STB in WAIT cycle 3 → slave STB drops next edge, no master ACK. Repeat with PHY_RST_I=1 mid-WAIT → all outputs 0 next edge; a following transaction completes normally.
- Stray ACK and tie: S_WB_ACK_I[1]=1 while slave 3 is selected → ignored. Slave 3 ACK on the TIMEOUT cycle → ERR=0 with slave data returned.
